// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared car-controller types and sizing constants.
// Revision : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int NFLOORS = 4;
    localparam int FW      = $clog2(NFLOORS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_OPEN  = 2'd2,
        S_CLOSE = 2'd3
    } state_t;

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/rise_det.sv
`default_nettype none
// ============================================================================
// Module   : rise_det
// Purpose  : 0->1 detector for a level-type timer "done" signal.
// Revision : 1.0 - initial release
// ============================================================================
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic r_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d <= 1'b0;
        end else begin
            r_d <= d;
        end
    end

    assign rise = d & ~r_d;

endmodule : rise_det
`default_nettype wire

// File: rtl/floor_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : floor_sequencer
// Purpose  : Collective-control car sequencer driving the run and door timers.
// Revision : 1.0 - initial release
// ============================================================================
module floor_sequencer #(
    parameter int NFLOORS = elevator_pkg::NFLOORS,
    parameter int FW      = elevator_pkg::FW
) (
    input  logic               CP,
    input  logic               nCR,
    input  logic [NFLOORS-1:0] call,
    input  logic               endRun,
    input  logic               endOpen,
    output logic               mv2nxt,
    output logic               opendoor,
    output logic [FW-1:0]      floor,
    output logic               dir,
    output logic [NFLOORS-1:0] pending
);

    import elevator_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FW-1:0]      r_floor;
    logic [FW-1:0]      w_floor_nxt;
    logic [FW-1:0]      w_step;
    logic               r_dir;
    logic               w_dir_nxt;
    logic [NFLOORS-1:0] r_pend;
    logic [NFLOORS-1:0] w_pend_nxt;
    logic [NFLOORS-1:0] w_clr;
    logic               r_mv;
    logic               r_open;
    logic               w_at_end;
    logic               w_run_rise;
    logic               w_open_rise;

    // True when any request in p lies strictly beyond floor f in direction up.
    function automatic logic ahead(input logic [NFLOORS-1:0] p,
                                   input logic [FW-1:0]      f,
                                   input logic               up);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (p[i] && (up ? (i > int'(f)) : (i < int'(f)))) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    rise_det u_run_det (
        .clk   (CP),
        .rst_n (nCR),
        .d     (endRun),
        .rise  (w_run_rise)
    );

    rise_det u_open_det (
        .clk   (CP),
        .rst_n (nCR),
        .d     (endOpen),
        .rise  (w_open_rise)
    );

    always_comb begin
        w_clr = '0;
        if (r_state == S_OPEN) begin
            w_clr[r_floor] = 1'b1;
        end
        w_pend_nxt = (r_pend | call) & ~w_clr;
        w_step     = r_dir ? (r_floor + FW'(1)) : (r_floor - FW'(1));
        w_at_end   = r_dir ? (r_floor == FW'(NFLOORS - 1)) : (r_floor == '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir;
        case (r_state)
            S_IDLE: begin
                if (r_pend[r_floor]) begin
                    w_state_nxt = S_OPEN;
                end else if (ahead(r_pend, r_floor, r_dir)) begin
                    w_state_nxt = S_RUN;
                end else if (ahead(r_pend, r_floor, ~r_dir)) begin
                    w_state_nxt = S_RUN;
                    w_dir_nxt   = ~r_dir;
                end
            end
            S_RUN: begin
                if (w_run_rise) begin
                    // A run is only started toward a request, so the end stop
                    // is never reached here; the guard keeps floor in range.
                    if (w_at_end) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_floor_nxt = w_step;
                        if (w_pend_nxt[w_step]) begin
                            w_state_nxt = S_OPEN;
                        end else if (!ahead(w_pend_nxt, w_step, r_dir)) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            S_OPEN: begin
                if (w_open_rise) begin
                    w_state_nxt = S_CLOSE;
                end
            end
            S_CLOSE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (!nCR) begin
            r_state <= S_IDLE;
            r_floor <= '0;
            r_dir   <= 1'b1;
            r_pend  <= '0;
            r_mv    <= 1'b0;
            r_open  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_floor <= w_floor_nxt;
            r_dir   <= w_dir_nxt;
            r_pend  <= w_pend_nxt;
            r_mv    <= (w_state_nxt == S_RUN);
            r_open  <= (w_state_nxt == S_OPEN);
        end
    end

    assign mv2nxt   = r_mv;
    assign opendoor = r_open;
    assign floor    = r_floor;
    assign dir      = r_dir;
    assign pending  = r_pend;

endmodule : floor_sequencer
`default_nettype wire
